// File: rtl/cpu_trace_pkg.sv
// Shared types and entry-layout helpers for the CPU trace buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a. TRACE_TIMESTAMP_EN adds a 16-bit timestamp field to each entry.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Bit positions inside the 4-bit flags field {Z,N,C,O}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    localparam int TS_W = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_FIELD_W = TS_W;
`else
    localparam int TS_FIELD_W = 0;
`endif

    // Entry layout, LSB first: ALUOut, Flags, IR, PC, [TS]
    function automatic int flags_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int ir_lsb(input int data_w);
        return data_w + 4;
    endfunction

    function automatic int pc_lsb(input int ir_w, input int data_w);
        return ir_w + data_w + 4;
    endfunction

    function automatic int ts_lsb(input int addr_w, input int ir_w, input int data_w);
        return addr_w + ir_w + data_w + 4;
    endfunction

    function automatic int entry_w(input int addr_w, input int ir_w, input int data_w);
        return ts_lsb(addr_w, ir_w, data_w) + TS_FIELD_W;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Bundles the traced CPU state, trigger controls, status and drain read port.
// Latency: n/a (wiring only).
// Backpressure: RdReady from the consumer stalls the drain; capture side has none.
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IR_W   = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ENTRY_W = entry_w(ADDR_W, IR_W, DATA_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic              Arm;
    logic              SampleEn;
    logic              TrigEn;
    logic [ADDR_W-1:0] TrigPC;
    logic              ForceTrig;
    logic [ADDR_W-1:0] PCIn;
    logic [IR_W-1:0]   IRIn;
    logic [3:0]        FlagsIn;
    logic [DATA_W-1:0] ALUOutIn;

    logic              Busy;
    logic              Triggered;
    logic              Done;
    logic              Wrapped;
    logic [CNT_W-1:0]  Count;

    logic              RdValid;
    logic              RdReady;
    logic [ENTRY_W-1:0] RdData;
    logic              RdLast;

    // Tapped system / consumer side
    modport master (
        output Arm, SampleEn, TrigEn, TrigPC, ForceTrig,
        output PCIn, IRIn, FlagsIn, ALUOutIn, RdReady,
        input  Busy, Triggered, Done, Wrapped, Count,
        input  RdValid, RdData, RdLast
    );

    // Trace buffer side
    modport slave (
        input  Arm, SampleEn, TrigEn, TrigPC, ForceTrig,
        input  PCIn, IRIn, FlagsIn, ALUOutIn, RdReady,
        output Busy, Triggered, Done, Wrapped, Count,
        output RdValid, RdData, RdLast
    );

endinterface

// File: rtl/trace_ram.sv
// Entry storage for the trace buffer: DEPTH x ENTRY_W.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the controller decides when to write.
module trace_ram #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 44
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of PC/IR/flags/ALUOut with pre- and post-trigger history.
// Latency: sample written on the edge it is qualified; drain data visible the first DRAIN cycle.
// Backpressure: RdReady low holds RdData/rptr; capture never stalls. TRACE_TIMESTAMP_EN adds timestamps.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int IR_W      = 16,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    cpu_trace_buffer_if.slave  bus
);

    localparam int ENTRY_W = entry_w(ADDR_W, IR_W, DATA_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_TRIG);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "cpu_trace_buffer: DEPTH must be a power of two >= 2");
    end
    if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post
        $fatal(1, "cpu_trace_buffer: POST_TRIG must be below DEPTH");
    end

    state_t           state, state_n;
    logic [PTR_W-1:0] wptr, wptr_n, rptr, rptr_n;
    logic [CNT_W-1:0] count, count_n, post_cnt, post_n;
    logic             triggered, trig_n, wrapped, wrap_n;
    logic             ram_we, trig_hit;
    logic [ENTRY_W-1:0] wdata, rdata;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    // Free-running cycle stamp, wraps naturally at 2^16
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end

    assign wdata = {ts, bus.PCIn, bus.IRIn, bus.FlagsIn, bus.ALUOutIn};
`else
    assign wdata = {bus.PCIn, bus.IRIn, bus.FlagsIn, bus.ALUOutIn};
`endif

    assign trig_hit = bus.SampleEn &&
                      (bus.ForceTrig || (bus.TrigEn && bus.PCIn == bus.TrigPC));

    trace_ram #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    // Control state register; a reset abandons any capture or drain in progress
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            state     <= state_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            count     <= count_n;
            post_cnt  <= post_n;
            triggered <= trig_n;
            wrapped   <= wrap_n;
        end
    end

    // Next-state: arm, capture with trigger/post countdown, then drain oldest-first
    always_comb begin
        state_n = state;
        wptr_n  = wptr;
        rptr_n  = rptr;
        count_n = count;
        post_n  = post_cnt;
        trig_n  = triggered;
        wrap_n  = wrapped;
        ram_we  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Arm) begin
                    state_n = PRE;
                    trig_n  = 1'b0;
                    wrap_n  = 1'b0;
                    count_n = '0;
                    wptr_n  = '0;
                end
            end
            PRE, POST: begin
                if (bus.SampleEn) begin
                    ram_we = 1'b1;
                    wptr_n = wptr + PTR_ONE;
                    if (count != FULL) count_n = count + CNT_ONE;
                    if (state == PRE && count == FULL) wrap_n = 1'b1;
                    if (state == PRE && trig_hit) begin
                        trig_n  = 1'b1;
                        post_n  = POST_LOAD;
                        state_n = (POST_TRIG == 0) ? DRAIN : POST;
                    end
                    if (state == POST) begin
                        post_n = post_cnt - CNT_ONE;
                        if (post_cnt == CNT_ONE) state_n = DRAIN;
                    end
                end
                // Oldest entry sits Count slots behind the write pointer
                if (state_n == DRAIN) rptr_n = wptr_n - count_n[PTR_W-1:0];
            end
            DRAIN: begin
                if (bus.RdReady) begin
                    rptr_n  = rptr + PTR_ONE;
                    count_n = count - CNT_ONE;
                    if (count == CNT_ONE) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Busy      = (state == PRE) || (state == POST);
    assign bus.Done      = (state == DRAIN);
    assign bus.Triggered = triggered;
    assign bus.Wrapped   = wrapped;
    assign bus.Count     = count;
    assign bus.RdValid   = (state == DRAIN);
    assign bus.RdLast    = (state == DRAIN) && (count == CNT_ONE);
    assign bus.RdData    = (state == DRAIN) ? rdata : '0;

endmodule
